// File: rtl/pps_pkg.sv
// Shared definitions for the PPS sample scheduler: FSM state encodings,
// output record field layout and a record packing helper.
package pps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } pps_state_e;

    localparam int REC_WIDTH       = 64;
    localparam int REC_SAMPLES_LSB = 0;
    localparam int REC_SAMPLES_MSB = 31;
    localparam int REC_SECONDS_LSB = 32;
    localparam int REC_SECONDS_MSB = 63;

    localparam logic [31:0] SAMPLE_COUNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [REC_WIDTH-1:0] pack_record(
        input logic [31:0] seconds,
        input logic [31:0] samples
    );
        logic [REC_WIDTH-1:0] rec;
        rec = '0;
        rec[REC_SECONDS_MSB:REC_SECONDS_LSB] = seconds;
        rec[REC_SAMPLES_MSB:REC_SAMPLES_LSB] = samples;
        return rec;
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Synchronises the asynchronous PPS pin into the local clock domain and
// emits a registered single-cycle pulse on each rising edge.
module pps_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pps_async,
    output logic pps_pulse
);

    // Fewer than two stages would not give a metastability-safe crossing.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              pulse_q;
    logic              pulse_d;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], pps_async};
        prev_d  = sync_q[STAGES-1];
        pulse_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pps_pulse = pulse_q;

endmodule

// File: rtl/pps_sample_scheduler.sv
// Arms on request, starts counting samples on the next PPS and emits one
// {seconds, samples_in_second} record per subsequent PPS through a one-entry
// AXI-Stream register; detects PPS loss while running.
module pps_sample_scheduler
    import pps_pkg::*;
#(
    parameter int unsigned PPS_TIMEOUT_CYCLES = 125_000_000,
    parameter int          SYNC_STAGES        = 2
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic        pps_in,
    input  logic        cfg_arm,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_interval,
    input  logic        i_sample_valid,
    output logic        o_stop_sample_counter,
    output logic [31:0] o_interval,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [1:0]  o_state,
    output logic        o_overflow,
    output logic        o_pps_lost
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(PPS_TIMEOUT_CYCLES);

    logic pps_pulse;

    pps_state_e     state_q;
    pps_state_e     state_d;
    logic           stop_q;
    logic           stop_d;
    logic [31:0]    interval_q;
    logic [31:0]    interval_d;
    logic [31:0]    seconds_q;
    logic [31:0]    seconds_d;
    logic [31:0]    samples_q;
    logic [31:0]    samples_d;
    logic [31:0]    timer_q;
    logic [31:0]    timer_d;
    logic [63:0]    tdata_q;
    logic [63:0]    tdata_d;
    logic           tvalid_q;
    logic           tvalid_d;
    logic           overflow_q;
    logic           overflow_d;
    logic           pps_lost_q;
    logic           pps_lost_d;
    logic           rec_load;
    logic [63:0]    record;

    pps_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (axis_aclk),
        .rst       (axis_aresetn),
        .pps_async (pps_in),
        .pps_pulse (pps_pulse)
    );

    // Disable overrides everything; the sample sitting on the PPS cycle
    // belongs to the new second, so it seeds the next count.
    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        seconds_d  = seconds_q;
        samples_d  = samples_q;
        timer_d    = timer_q;
        pps_lost_d = pps_lost_q;
        rec_load   = 1'b0;
        record     = pack_record(seconds_q + 32'd1, samples_q);

        if (!cfg_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (pps_pulse) begin
                        state_d    = ST_RUN;
                        interval_d = cfg_interval;
                        seconds_d  = '0;
                        samples_d  = '0;
                        timer_d    = '0;
                    end
                end
                ST_RUN: begin
                    if (pps_pulse) begin
                        rec_load  = 1'b1;
                        seconds_d = seconds_q + 32'd1;
                        samples_d = {31'd0, i_sample_valid};
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                        if (i_sample_valid && (samples_q != SAMPLE_COUNT_MAX)) begin
                            samples_d = samples_q + 32'd1;
                        end
                        if (timer_d >= TIMEOUT_LIMIT) begin
                            state_d    = ST_FAULT;
                            pps_lost_d = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (!cfg_arm) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // One-entry output register: a busy entry is never overwritten unless
    // it is being accepted in the same cycle.
    always_comb begin
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;
        stop_d     = (state_d != ST_RUN);

        if (rec_load) begin
            if (tvalid_q && !m_axis_tready) begin
                overflow_d = 1'b1;
            end else begin
                tdata_d  = record;
                tvalid_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            state_q    <= ST_IDLE;
            stop_q     <= 1'b1;
            interval_q <= '0;
            seconds_q  <= '0;
            samples_q  <= '0;
            timer_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            pps_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            interval_q <= interval_d;
            seconds_q  <= seconds_d;
            samples_q  <= samples_d;
            timer_q    <= timer_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
            pps_lost_q <= pps_lost_d;
        end
    end

    assign o_state               = state_q;
    assign o_stop_sample_counter = stop_q;
    assign o_interval            = interval_q;
    assign m_axis_tdata          = tdata_q;
    assign m_axis_tvalid         = tvalid_q;
    assign o_overflow            = overflow_q;
    assign o_pps_lost            = pps_lost_q;

endmodule

// File: tb/tb_pps_sample_scheduler.sv
// Self-checking bench for pps_sample_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural model of the scheduler.
module tb_pps_sample_scheduler;

    localparam int SYNC          = 2;
    localparam int MAIN_TIMEOUT  = 20000;
    localparam int SHORT_TIMEOUT = 100;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pps;
    logic        arm;
    logic        en;
    logic [31:0] interval;
    logic        valid;
    logic        tready;

    logic        stop;
    logic [31:0] o_interval;
    logic [63:0] tdata;
    logic        tvalid;
    logic [1:0]  state;
    logic        ovf;
    logic        lost;

    logic        sh_stop;
    logic [31:0] sh_interval;
    logic [63:0] sh_tdata;
    logic        sh_tvalid;
    logic [1:0]  sh_state;
    logic        sh_ovf;
    logic        sh_lost;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [1:0]  m_state;
    logic [31:0] m_interval;
    logic [31:0] m_secs;
    logic [31:0] m_cnt;
    int unsigned m_since;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_ovf;
    logic        m_lost;
    logic [7:0]  hist;

    pps_sample_scheduler #(
        .PPS_TIMEOUT_CYCLES (MAIN_TIMEOUT),
        .SYNC_STAGES        (SYNC)
    ) u_dut (
        .axis_aclk             (clk),
        .axis_aresetn          (rst),
        .pps_in                (pps),
        .cfg_arm               (arm),
        .cfg_enable            (en),
        .cfg_interval          (interval),
        .i_sample_valid        (valid),
        .o_stop_sample_counter (stop),
        .o_interval            (o_interval),
        .m_axis_tdata          (tdata),
        .m_axis_tvalid         (tvalid),
        .m_axis_tready         (tready),
        .o_state               (state),
        .o_overflow            (ovf),
        .o_pps_lost            (lost)
    );

    pps_sample_scheduler #(
        .PPS_TIMEOUT_CYCLES (SHORT_TIMEOUT),
        .SYNC_STAGES        (SYNC)
    ) u_dut_short (
        .axis_aclk             (clk),
        .axis_aresetn          (rst),
        .pps_in                (pps),
        .cfg_arm               (arm),
        .cfg_enable            (en),
        .cfg_interval          (interval),
        .i_sample_valid        (valid),
        .o_stop_sample_counter (sh_stop),
        .o_interval            (sh_interval),
        .m_axis_tdata          (sh_tdata),
        .m_axis_tvalid         (sh_tvalid),
        .m_axis_tready         (tready),
        .o_state               (sh_state),
        .o_overflow            (sh_ovf),
        .o_pps_lost            (sh_lost)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state    = S_IDLE;
        m_interval = '0;
        m_secs     = '0;
        m_cnt      = '0;
        m_since    = 0;
        m_tdata    = '0;
        m_tvalid   = 1'b0;
        m_ovf      = 1'b0;
        m_lost     = 1'b0;
        hist       = '0;
    endtask

    // A pin rise is seen by the scheduler SYNC+1 cycles later as a pulse.
    task automatic model_edge();
        logic        pulse;
        logic        load;
        logic [63:0] rec;
        hist  = {hist[6:0], pps};
        pulse = hist[SYNC+1] && !hist[SYNC+2];
        load  = 1'b0;
        rec   = '0;
        if (!en) begin
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE:  if (arm) m_state = S_ARMED;
                S_ARMED: if (pulse) begin
                    m_state    = S_RUN;
                    m_interval = interval;
                    m_secs     = 0;
                    m_cnt      = 0;
                    m_since    = 0;
                end
                S_RUN: if (pulse) begin
                    load    = 1'b1;
                    m_secs  = m_secs + 1;
                    rec     = {m_secs, m_cnt};
                    m_cnt   = valid ? 32'd1 : 32'd0;
                    m_since = 0;
                end else begin
                    m_since++;
                    if (valid && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                    if (m_since >= MAIN_TIMEOUT) begin
                        m_state = S_FAULT;
                        m_lost  = 1'b1;
                    end
                end
                default: if (!arm) m_state = S_IDLE;
            endcase
        end
        if (load) begin
            if (m_tvalid && !tready) m_ovf = 1'b1;
            else begin
                m_tdata  = rec;
                m_tvalid = 1'b1;
            end
        end else if (m_tvalid && tready) begin
            m_tvalid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Pin high for four cycles; the internal pulse lands on the last step.
    task automatic pps_edge();
        pps = 1'b1;
        repeat (4) step();
        pps = 1'b0;
    endtask

    task automatic arm_and_enter_run(input logic [31:0] iv);
        en       = 1'b1;
        interval = iv;
        arm      = 1'b1;
        step();
        arm      = 1'b0;
        pps_edge();
    endtask

    task automatic test_reset();
        pps = 1'($urandom); arm = 1'($urandom); en = 1'($urandom);
        valid = 1'($urandom); tready = 1'($urandom); interval = $urandom;
        do_reset();
        checks++; if (state !== S_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        checks++; if (stop !== 1'b1) begin errors++; $display("[TB] FAIL reset_stop: got %0b expected 1", stop); end
        checks++; if (o_interval !== 32'd0) begin errors++; $display("[TB] FAIL reset_interval: got %0d expected 0", o_interval); end
        checks++; if (tdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", tdata); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", tvalid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", ovf); end
        checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_pps_lost: got %0b expected 0", lost); end
    endtask

    task automatic test_basic_record();
        do_reset();
        pps = 0; valid = 1; tready = 0; en = 1; interval = 32'd1000;
        arm = 1; step(); arm = 0;
        checks++; if (state !== S_ARMED || stop !== 1'b1) begin errors++; $display("[TB] FAIL armed_state: got state %0d stop %0b expected 1 1", state, stop); end
        interval = 32'd77;
        pps_edge();
        interval = 32'd1000;
        checks++; if (state !== S_RUN) begin errors++; $display("[TB] FAIL run_entry_state: got %0d expected %0d", state, S_RUN); end
        checks++; if (stop !== 1'b0) begin errors++; $display("[TB] FAIL run_entry_stop: got %0b expected 0", stop); end
        checks++; if (o_interval !== 32'd77) begin errors++; $display("[TB] FAIL latched_interval: got %0d expected 77", o_interval); end
        repeat (4997) step();
        checks++; if (o_interval !== 32'd77) begin errors++; $display("[TB] FAIL interval_hold: got %0d expected 77", o_interval); end
        pps_edge();
        checks++; if (tvalid !== 1'b1 || tdata !== {32'd1, 32'd5000}) begin errors++; $display("[TB] FAIL first_record: got valid %0b data %h expected 1 %h", tvalid, tdata, {32'd1, 32'd5000}); end
        checks++; if (tdata !== m_tdata) begin errors++; $display("[TB] FAIL first_record_model: got %h expected %h", tdata, m_tdata); end
    endtask

    task automatic test_overflow();
        logic [63:0] held;
        do_reset();
        pps = 0; tready = 0; valid = 0;
        arm_and_enter_run($urandom);
        repeat (50) begin valid = 1'($urandom); step(); end
        pps_edge();
        held = m_tdata;
        checks++; if (tvalid !== 1'b1 || tdata !== held || ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_first: got valid %0b data %h ovf %0b expected 1 %h 0", tvalid, tdata, ovf, held); end
        repeat (50) begin valid = 1'($urandom); step(); end
        pps_edge();
        checks++; if (tdata !== held || tvalid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_held: got valid %0b data %h expected 1 %h", tvalid, tdata, held); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pps = 0; tready = 0; valid = 1;
        arm_and_enter_run($urandom);
        repeat (30) step();
        pps_edge();
        repeat (30) step();
        pps = 1;
        repeat (3) step();
        tready = 1;
        step();
        tready = 0; pps = 0;
        checks++; if (tvalid !== 1'b1 || tdata[63:32] !== 32'd2) begin errors++; $display("[TB] FAIL b2b_replace: got valid %0b seconds %0d expected 1 2", tvalid, tdata[63:32]); end
        checks++; if (tdata !== m_tdata || ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_model: got %h ovf %0b expected %h 0", tdata, ovf, m_tdata); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        pps = 0; tready = 0; valid = 1;
        arm_and_enter_run($urandom);
        repeat (20) step();
        pps_edge();
        en = 0;
        step();
        checks++; if (state !== S_IDLE || stop !== 1'b1 || tvalid !== 1'b1) begin errors++; $display("[TB] FAIL disable_idle: got state %0d stop %0b valid %0b expected 0 1 1", state, stop, tvalid); end
        repeat (3) step();
        checks++; if (tdata !== m_tdata || tdata[63:32] !== 32'd1) begin errors++; $display("[TB] FAIL disable_pending: got %h expected %h", tdata, m_tdata); end
        tready = 1;
        step();
        tready = 0;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL disable_delivered: got %0b expected 0", tvalid); end
        en = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        pps = 0; tready = 1; valid = 0;
        arm_and_enter_run($urandom);
        repeat (3) step();
        force u_dut.samples_q = 32'hFFFF_FFFE;
        #1;
        release u_dut.samples_q;
        m_cnt = 32'hFFFF_FFFE;
        valid = 1;
        repeat (3) step();
        valid = 0;
        repeat (2) step();
        pps_edge();
        checks++; if (tvalid !== 1'b1 || tdata[31:0] !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL saturation: got valid %0b samples %h expected 1 ffffffff", tvalid, tdata[31:0]); end
    endtask

    task automatic test_timeout();
        do_reset();
        pps = 0; tready = 0; valid = 1;
        arm_and_enter_run(32'd4242);
        repeat (SHORT_TIMEOUT - 1) step();
        checks++; if (sh_state !== S_RUN || sh_lost !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got state %0d lost %0b expected 2 0", sh_state, sh_lost); end
        step();
        checks++; if (sh_state !== S_FAULT) begin errors++; $display("[TB] FAIL timeout_state: got %0d expected %0d", sh_state, S_FAULT); end
        checks++; if (sh_lost !== 1'b1 || sh_stop !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flags: got lost %0b stop %0b expected 1 1", sh_lost, sh_stop); end
        checks++; if (sh_interval !== 32'd4242 || sh_tvalid !== 1'b0 || sh_tdata !== 64'd0 || sh_ovf !== 1'b0) begin errors++; $display("[TB] FAIL timeout_misc: got iv %0d valid %0b data %h ovf %0b expected 4242 0 0 0", sh_interval, sh_tvalid, sh_tdata, sh_ovf); end
        checks++; if (state !== S_RUN || lost !== 1'b0) begin errors++; $display("[TB] FAIL timeout_main: got state %0d lost %0b expected 2 0", state, lost); end
        step();
        checks++; if (sh_state !== S_IDLE || sh_lost !== 1'b1) begin errors++; $display("[TB] FAIL fault_exit: got state %0d lost %0b expected 0 1", sh_state, sh_lost); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        pps = 0; tready = 0; valid = 1;
        arm_and_enter_run(32'd99);
        repeat (20) step();
        pps_edge();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (state !== S_IDLE || stop !== 1'b1 || o_interval !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_ctrl: got state %0d stop %0b iv %0d expected 0 1 0", state, stop, o_interval); end
        checks++; if (tvalid !== 1'b0 || tdata !== 64'd0 || ovf !== 1'b0 || lost !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_out: got valid %0b data %h ovf %0b lost %0b expected 0 0 0 0", tvalid, tdata, ovf, lost); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int gap;
        int off;
        do_reset();
        en = 1; arm = 0; pps = 0; gap = 40; off = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            valid    = 1'($urandom);
            tready   = ($urandom_range(0, 3) != 0);
            interval = $urandom;
            arm      = ($urandom_range(0, 15) == 0);
            if (off > 0) off--;
            else if ($urandom_range(0, 299) == 0) off = $urandom_range(1, 4);
            en  = (off == 0);
            pps = (gap < 4);
            if (gap == 0) gap = $urandom_range(30, 300);
            else gap--;
            step();
            checks++; if (state !== m_state) begin errors++; $display("[TB] FAIL rand_state @%0d: got %0d expected %0d", cyc, state, m_state); end
            checks++; if (stop !== (m_state != S_RUN)) begin errors++; $display("[TB] FAIL rand_stop @%0d: got %0b expected %0b", cyc, stop, m_state != S_RUN); end
            checks++; if (o_interval !== m_interval) begin errors++; $display("[TB] FAIL rand_interval @%0d: got %0d expected %0d", cyc, o_interval, m_interval); end
            checks++; if (tvalid !== m_tvalid) begin errors++; $display("[TB] FAIL rand_tvalid @%0d: got %0b expected %0b", cyc, tvalid, m_tvalid); end
            checks++; if (m_tvalid && tdata !== m_tdata) begin errors++; $display("[TB] FAIL rand_tdata @%0d: got %h expected %h", cyc, tdata, m_tdata); end
            checks++; if (ovf !== m_ovf || lost !== m_lost) begin errors++; $display("[TB] FAIL rand_flags @%0d: got ovf %0b lost %0b expected %0b %0b", cyc, ovf, lost, m_ovf, m_lost); end
        end
    endtask

    initial begin
        rst = 1'b1; pps = 0; arm = 0; en = 0; interval = '0; valid = 0; tready = 0;
        model_reset();
        test_reset();
        test_basic_record();
        test_overflow();
        test_back_to_back();
        test_enable_drop();
        test_saturation();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pps_sample_scheduler.md
PPS_SAMPLE_SCHEDULER -- requirements
Module: pps_sample_scheduler

Interface
REQ-001 SHALL have parameter PPS_TIMEOUT_CYCLES, default 125_000_000, max axis_aclk cycles allowed between PPS edges in RUN.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, PPS synchroniser depth (min 2).
REQ-003 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-004 axis_aclk  in  1  sole clock.
REQ-005 axis_aresetn  in  1  asynchronous, active-high reset.
REQ-006 pps_in  in  1  asynchronous PPS from GNSS receiver.
REQ-007 cfg_arm  in  1  level; start request.
REQ-008 cfg_enable  in  1  level; low forces return to IDLE.
REQ-009 cfg_interval  in  32  sample-counter interval to program.
REQ-010 i_sample_valid  in  1  one sample accepted this cycle.
REQ-011 o_stop_sample_counter  out  1  stop gate to sample counter.
REQ-012 o_interval  out  32  interval presented to sample counter.
REQ-013 m_axis_tdata  out  64  {seconds[63:32], samples_in_second[31:0]}.
REQ-014 m_axis_tvalid  out  1  record valid.
REQ-015 m_axis_tready  in  1  downstream accept.
REQ-016 o_state  out  2  current FSM state.
REQ-017 o_overflow  out  1  sticky; record dropped.
REQ-018 o_pps_lost  out  1  sticky; PPS timeout occurred.

Function
REQ-019 pps_in SHALL pass through SYNC_STAGES flops then rising-edge detect, giving one-cycle pps_pulse SYNC_STAGES+1 cycles after the pin edge.
REQ-020 FSM states SHALL be IDLE(0), ARMED(1), RUN(2), FAULT(3).
REQ-021 IDLE->ARMED when cfg_arm && cfg_enable.
REQ-022 ARMED->RUN on pps_pulse; o_interval SHALL latch cfg_interval on this transition only and hold throughout RUN.
REQ-023 RUN->FAULT when the cycle-since-PPS counter reaches PPS_TIMEOUT_CYCLES; o_pps_lost set.
REQ-024 FAULT->IDLE when cfg_arm is low.
REQ-025 Any state->IDLE next cycle when cfg_enable is low; this takes priority over all other transitions.
REQ-026 cfg_arm SHALL be ignored in ARMED and RUN.
REQ-027 o_stop_sample_counter SHALL be 0 only in RUN, registered, same cycle as o_state.
REQ-028 In RUN, a 32-bit sample count SHALL increment on i_sample_valid, saturating at 0xFFFF_FFFF.
REQ-029 On pps_pulse in RUN, a record {seconds, sample count} SHALL be loaded; next-cycle sample count = i_sample_valid ? 1 : 0; seconds +1, wrapping at 2^32.
REQ-030 The first pps_pulse (ARMED->RUN) SHALL zero both counters and emit no record.
REQ-031 Output is a one-entry register: m_axis_tvalid held with stable tdata until tready.
REQ-032 Record load while tvalid && !tready SHALL drop the new record, keep the old, set o_overflow.
REQ-033 Record load in the same cycle as tvalid && tready SHALL replace the entry and keep tvalid high; no overflow.
REQ-034 A pending record SHALL still be delivered after leaving RUN.

Reset
REQ-035 On reset: state IDLE, o_stop_sample_counter 1, o_interval 0, tdata 0, tvalid 0, o_overflow 0, o_pps_lost 0, counters 0, synchroniser 0.
REQ-036 Reset mid-RUN SHALL discard a pending record immediately.
REQ-037 Sticky flags SHALL clear only on reset.

Structure
REQ-038 State encodings and record field offsets SHALL reside in shared package pps_pkg.
REQ-039 The synchroniser and edge detector SHALL be sub-module pps_sync_edge.

Verification
REQ-040 cfg_interval=1000, arm, PPS, valid every cycle, PPS 5000 cycles later -> o_interval=1000; record {1,5000}; stop low from cycle after RUN entry.
REQ-041 tready=0, two RUN PPS -> first record held, o_overflow=1, tdata unchanged.
REQ-042 PPS_TIMEOUT_CYCLES=100, no PPS after RUN entry -> state FAULT at cycle 100, o_pps_lost=1, stop=1.
REQ-043 cfg_enable low mid-RUN with pending record -> IDLE next cycle; record still delivered on tready.
REQ-044 Sample count preset 0xFFFF_FFFE, three valids, then PPS -> samples field 0xFFFF_FFFF.
REQ-045 Reset asserted mid-RUN with tvalid=1 -> all outputs at REQ-035 values asynchronously.
